// File: rtl/eda_regional_max_pkg.sv
// Shared types and default geometry for the eda_regional_max host front end.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_PIXEL_WIDTH
`define CFG_PIXEL_WIDTH 8
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH (`CFG_I_WIDTH + `CFG_J_WIDTH)
`endif

package eda_regional_max_pkg;

  localparam int CFG_M_DEF           = `CFG_M;
  localparam int CFG_N_DEF           = `CFG_N;
  localparam int CFG_PIXEL_WIDTH_DEF = `CFG_PIXEL_WIDTH;
  localparam int CFG_I_WIDTH_DEF     = `CFG_I_WIDTH;
  localparam int CFG_J_WIDTH_DEF     = `CFG_J_WIDTH;
  localparam int CFG_ADDR_WIDTH_DEF  = `CFG_ADDR_WIDTH;

  // Frame lifecycle: load pixels, let the last write land, kick the core,
  // wait for a fresh done edge, then stream the result mask out.
  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    FLUSH = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } host_state_e;

endpackage

// File: rtl/eda_row_serializer.sv
// Captures the core's M x N result mask and presents it one row per
// valid/ready beat, holding the current beat stable while stalled.
module eda_row_serializer
  import eda_regional_max_pkg::*;
#(
  parameter int M       = CFG_M_DEF,
  parameter int N       = CFG_N_DEF,
  parameter int I_WIDTH = CFG_I_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     capture_i,
  input  logic [M-1:0][N-1:0]      matrix_i,
  output logic                     row_valid_o,
  input  logic                     row_ready_i,
  output logic [N-1:0]             row_data_o,
  output logic [I_WIDTH-1:0]       row_idx_o,
  output logic                     row_last_o,
  output logic                     drain_done_o
);

  logic [M-1:0][N-1:0] cap_q;
  logic [I_WIDTH-1:0]  row_q;
  logic                valid_q;
  logic                at_last;
  logic                row_hs;

  assign at_last = (row_q == I_WIDTH'(M - 1));
  assign row_hs  = valid_q & row_ready_i;

  // Snapshot the mask on the done edge; walk rows on each accepted beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else if (capture_i) begin
      cap_q   <= matrix_i;
      row_q   <= '0;
      valid_q <= 1'b1;
    end else if (row_hs) begin
      if (at_last) begin
        row_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        row_q <= row_q + 1'b1;
      end
    end
  end

  // Data and last are forced low between frames so the bus idles at zero.
  assign row_valid_o  = valid_q;
  assign row_data_o   = valid_q ? cap_q[row_q] : '0;
  assign row_idx_o    = row_q;
  assign row_last_o   = valid_q & at_last;
  assign drain_done_o = row_hs & at_last;

endmodule

// File: rtl/eda_regional_max_host_if.sv
// Host front end for eda_regional_max: turns a raster pixel stream into
// {i,j}-addressed core writes, starts the core once per frame, and hands
// the result mask back row by row.
module eda_regional_max_host_if
  import eda_regional_max_pkg::*;
#(
  parameter int M           = CFG_M_DEF,
  parameter int N           = CFG_N_DEF,
  parameter int PIXEL_WIDTH = CFG_PIXEL_WIDTH_DEF,
  parameter int I_WIDTH     = CFG_I_WIDTH_DEF,
  parameter int J_WIDTH     = CFG_J_WIDTH_DEF,
  parameter int ADDR_WIDTH  = CFG_ADDR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_pix_valid,
  output logic                   s_pix_ready,
  input  logic [PIXEL_WIDTH-1:0] s_pix_data,
  output logic [ADDR_WIDTH-1:0]  core_wr_addr,
  output logic [PIXEL_WIDTH-1:0] core_pixel_in,
  output logic                   core_write_en,
  output logic                   core_start,
  input  logic                   core_done,
  input  logic [M-1:0][N-1:0]    core_matrix,
  output logic                   m_row_valid,
  input  logic                   m_row_ready,
  output logic [N-1:0]           m_row_data,
  output logic [I_WIDTH-1:0]     m_row_idx,
  output logic                   m_row_last,
  output logic                   busy
);

  host_state_e            state_q;
  logic [I_WIDTH-1:0]     i_q;
  logic [J_WIDTH-1:0]     j_q;
  logic                   wr_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [PIXEL_WIDTH-1:0] wr_data_q;
  logic                   start_q;
  logic                   done_prev_q;

  logic                   accept;
  logic                   last_col;
  logic                   last_pix;
  logic                   done_rise;
  logic                   capture;
  logic                   drain_done;

  assign s_pix_ready = (state_q == LOAD);
  assign busy        = (state_q != LOAD);
  assign accept      = s_pix_valid & s_pix_ready;
  assign last_col    = (j_q == J_WIDTH'(N - 1));
  assign last_pix    = last_col && (i_q == I_WIDTH'(M - 1));
  // A done level already present on WAIT entry is stale; only a fresh
  // low-to-high transition counts as completion of this frame.
  assign done_rise   = core_done & ~done_prev_q;
  assign capture     = (state_q == WAIT) && done_rise;

  // Frame FSM, pixel/address counters and registered core-side strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= LOAD;
      i_q         <= '0;
      j_q         <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= core_done;
      wr_en_q     <= 1'b0;
      start_q     <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {i_q, j_q};
            wr_data_q <= s_pix_data;
            // Column wraps at N-1 so unused j codes never appear.
            if (last_col) begin
              j_q <= '0;
              i_q <= (i_q == I_WIDTH'(M - 1)) ? '0 : i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
            if (last_pix) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // Final write is on the bus this cycle; start follows it.
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= LOAD;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign core_write_en = wr_en_q;
  assign core_wr_addr  = wr_addr_q;
  assign core_pixel_in = wr_data_q;
  assign core_start    = start_q;

  eda_row_serializer #(
    .M       (M),
    .N       (N),
    .I_WIDTH (I_WIDTH)
  ) u_row_serializer (
    .clk          (clk),
    .reset_n      (reset_n),
    .capture_i    (capture),
    .matrix_i     (core_matrix),
    .row_valid_o  (m_row_valid),
    .row_ready_i  (m_row_ready),
    .row_data_o   (m_row_data),
    .row_idx_o    (m_row_idx),
    .row_last_o   (m_row_last),
    .drain_done_o (drain_done)
  );

endmodule
